square_wave_meter: RTL and testbench



---
 rtl/square_wave_meter_pkg.sv | 14 +
 rtl/square_wave_meter_unit_timer.sv | 42 ++++
 rtl/square_wave_meter.sv | 95 +++++++++
 tb/tb_square_wave_meter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/square_wave_meter_pkg.sv
// Shared types and defaults for the square-wave meter.
// The meter reports the high and low time of each full period.
package sqwave_pkg;

  localparam int DEF_TICK_DIV = 10;
  localparam int DEF_CNT_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

endpackage

// File: rtl/square_wave_meter_unit_timer.sv
// Prescaler plus saturating unit counter.
// A clear restarts the count from the current cycle.
module unit_timer
  import sqwave_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [PW-1:0] presc;

  assign at_max = (count == MAX);

  // The clear cycle itself is the first counted cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      count <= '0;
    end else if (clear) begin
      presc <= P_ONE;
      count <= '0;
    end else if (presc == P_LAST) begin
      presc <= '0;
      if (!at_max)
        count <= count + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/square_wave_meter.sv
// Measures on/off time of a square wave in units of TICK_DIV
// clocks, one strobed result per full period, plus stuck flag.
module square_wave_meter
  import sqwave_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_q,
  output logic [CNT_W-1:0] o_high,
  output logic [CNT_W-1:0] o_low,
  output logic             o_valid,
  output logic             o_stuck
);

  state_t           state;
  logic             q_r;
  logic             rise;
  logic             fall;
  logic             toggle;
  logic             hi_ok;
  logic             at_max;
  logic [CNT_W-1:0] units;
  logic [CNT_W-1:0] hi_reg;

  assign rise   = i_q & ~q_r;
  assign fall   = ~i_q & q_r;
  assign toggle = rise | fall;

  unit_timer #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (toggle),
    .count (units),
    .at_max(at_max)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      q_r     <= 1'b0;
      hi_ok   <= 1'b0;
      hi_reg  <= '0;
      o_high  <= '0;
      o_low   <= '0;
      o_valid <= 1'b0;
      o_stuck <= 1'b0;
    end else begin
      q_r     <= i_q;
      o_valid <= 1'b0;
      if (toggle)
        o_stuck <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise)
            state <= S_HIGH;
          else if (fall)
            state <= S_LOW;
        end
        S_HIGH: begin
          if (fall) begin
            hi_reg <= units;
            hi_ok  <= 1'b1;
            state  <= S_LOW;
          end else if (at_max) begin
            o_stuck <= 1'b1;
            hi_ok   <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_LOW: begin
          if (rise) begin
            if (hi_ok) begin
              o_high  <= hi_reg;
              o_low   <= units;
              o_valid <= 1'b1;
            end
            state <= S_HIGH;
          end else if (at_max) begin
            o_stuck <= 1'b1;
            hi_ok   <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_wave_meter.sv
// Bench for square_wave_meter: table rows, corner sequences and
// random periods, all checked against a phase-length model.
module tb_square_wave_meter;

  localparam int TD   = 10;
  localparam int CW   = 8;
  localparam int MAXU = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          q;
  logic [CW-1:0] high;
  logic [CW-1:0] low;
  logic          valid;
  logic          stuck;

  always #5 clk = ~clk;

  square_wave_meter #(
    .TICK_DIV(TD),
    .CNT_W   (CW)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_q    (q),
    .o_high (high),
    .o_low  (low),
    .o_valid(valid),
    .o_stuck(stuck)
  );

  int errors = 0;
  int checks = 0;
  int dut_nv = 0;

  // model: mode 0 idle, 1 in high phase, 2 in low phase
  int m_prev, m_mode, m_len, m_hi, m_hiok;
  int e_high, e_low, e_valid, e_stuck;

  typedef struct {
    int hi_c;
    int lo_c;
    int reps;
    int exp_h;
    int exp_l;
  } vec_t;

  vec_t vt[7];

  function automatic int dur(int l);
    return (l / TD > MAXU) ? MAXU : l / TD;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = 0;
    m_mode  = 0;
    m_len   = 0;
    m_hi    = 0;
    m_hiok  = 0;
    e_high  = 0;
    e_low   = 0;
    e_valid = 0;
    e_stuck = 0;
  endtask

  task automatic model_step(input int qv);
    e_valid = 0;
    if (qv != m_prev) begin
      e_stuck = 0;
      if (m_mode == 1) begin
        m_hi   = dur(m_len);
        m_hiok = 1;
        m_mode = 2;
      end else if (m_mode == 2) begin
        if (m_hiok != 0) begin
          e_high  = m_hi;
          e_low   = dur(m_len);
          e_valid = 1;
        end
        m_mode = 1;
      end else begin
        m_mode = (qv != 0) ? 1 : 2;
      end
      m_len = 1;
    end else begin
      if (m_mode != 0 && m_len >= MAXU * TD) begin
        e_stuck = 1;
        m_hiok  = 0;
        m_mode  = 0;
      end
      m_len++;
    end
    m_prev = qv;
  endtask

  task automatic step(input logic qv);
    @(negedge clk);
    q = qv;
    model_step(int'(qv));
    @(posedge clk);
    #1;
    check("valid", valid, e_valid);
    check("stuck", stuck, e_stuck);
    check("high", high, e_high);
    check("low", low, e_low);
    if (valid)
      dut_nv++;
  endtask

  task automatic run(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int c = 0; c < h; c++) step(1'b1);
      for (int c = 0; c < l; c++) step(1'b0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_high", high, 0);
    check("rst_low", low, 0);
    check("rst_valid", valid, 0);
    check("rst_stuck", stuck, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_valid", valid, 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int nv0;
    vt[0] = '{27, 13, 3, 2, 1};
    vt[1] = '{9, 9, 3, 0, 0};
    vt[2] = '{10, 10, 3, 1, 1};
    vt[3] = '{1, 1, 4, 0, 0};
    vt[4] = '{50, 50, 3, 5, 5};
    vt[5] = '{150, 20, 3, 15, 2};
    vt[6] = '{19, 31, 3, 1, 3};

    rst = 1'b1;
    q   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_high", high, 0);
    check("init_low", low, 0);
    check("init_valid", valid, 0);
    check("init_stuck", stuck, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      nv0 = dut_nv;
      run(vt[i].hi_c, vt[i].lo_c, vt[i].reps);
      check("tbl_high", high, vt[i].exp_h);
      check("tbl_low", low, vt[i].exp_l);
      check("tbl_nvalid", (dut_nv - nv0) >= vt[i].reps - 1, 1);
    end

    // constant level long enough to saturate
    nv0 = dut_nv;
    for (int c = 0; c < MAXU * TD + 5; c++) step(1'b0);
    check("stuck_set", stuck, 1);
    check("stuck_no_valid", dut_nv - nv0, 0);
    step(1'b1);
    check("stuck_clear", stuck, 0);
    for (int c = 0; c < 9; c++) step(1'b1);
    for (int c = 0; c < 10; c++) step(1'b0);
    check("stuck_discard", dut_nv - nv0, 0);
    run(10, 10, 2);
    check("resume_high", high, 1);
    check("resume_low", low, 1);

    // high phase exactly at the saturation boundary
    for (int c = 0; c < MAXU * TD; c++) step(1'b1);
    for (int c = 0; c < 20; c++) step(1'b0);
    step(1'b1);
    check("sat_high", high, MAXU);
    check("sat_low", low, 2);
    check("sat_nostuck", stuck, 0);
    for (int c = 0; c < MAXU * TD; c++) step(1'b1);
    check("sat_stuck", stuck, 1);
    check("sat_hold", high, MAXU);
    run(0, 5, 1);

    // reset in the middle of a high phase
    run(20, 20, 2);
    for (int c = 0; c < 7; c++) step(1'b1);
    pulse_reset();
    nv0 = dut_nv;
    run(30, 10, 3);
    check("post_rst_high", high, 3);
    check("post_rst_low", low, 1);
    check("post_rst_nv", dut_nv - nv0, 2);

    // random period lengths
    for (int i = 0; i < 40; i++)
      run(int'($urandom_range(1, 60)),
          int'($urandom_range(1, 60)), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
